// File: rtl/sd_width_pack.sv
// sd_width_pack: packs `ratio` narrow srdy/drdy beats into one registered wide word.
// Optional end-of-packet flush of partial words is enabled by defining SD_WIDTH_PACK_LAST_EN.
module sd_width_pack #(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         c_srdy,
  output logic                         c_drdy,
  input  logic [width-1:0]             c_data,
  input  logic                         c_last,
  output logic                         ip_srdy,
  input  logic                         ip_drdy,
  output logic [width*ratio-1:0]       ip_data,
  output logic [$clog2(ratio+1)-1:0]   ip_count,
  output logic                         ip_last
);

  localparam int LW = $clog2(ratio);
  localparam int CW = $clog2(ratio+1);
  localparam int DW = width * ratio;

  logic [LW-1:0] r_lane;
  logic [DW-1:0] r_asm;
  logic          r_ipSrdy;
  logic [DW-1:0] r_ipData;
  logic [CW-1:0] r_ipCount;
  logic          r_ipLast;

  logic          w_last;
  logic          w_completing;
  logic          w_accept;
  logic [DW-1:0] w_merged;
  logic [CW-1:0] w_count;

`ifdef SD_WIDTH_PACK_LAST_EN
  assign w_last = c_last;
`else
  logic w_unusedLast;
  assign w_unusedLast = c_last;
  assign w_last       = 1'b0;
`endif

  assign w_completing = (r_lane == LW'(ratio-1)) | w_last;
  assign c_drdy       = !w_completing | !r_ipSrdy | ip_drdy;
  assign w_accept     = c_srdy & c_drdy;
  assign w_count      = CW'(r_lane) + CW'(1);

  // Current beat lands in its lane; lanes above it are zeroed so partial words are padded.
  always_comb begin
    w_merged = r_asm;
    for (int k = 0; k < ratio; k++) begin
      if (LW'(k) == r_lane) begin
        w_merged[k*width +: width] = c_data;
      end else if (k > int'(r_lane)) begin
        w_merged[k*width +: width] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lane <= '0;
      r_asm  <= '0;
    end else if (w_accept) begin
      if (w_completing) begin
        r_lane <= '0;
        r_asm  <= '0;
      end else begin
        r_lane <= r_lane + LW'(1);
        r_asm  <= w_merged;
      end
    end
  end

  // A completing accept reloads the holding register even while it drains, so no bubble appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ipSrdy  <= 1'b0;
      r_ipData  <= '0;
      r_ipCount <= '0;
      r_ipLast  <= 1'b0;
    end else if (w_accept && w_completing) begin
      r_ipSrdy  <= 1'b1;
      r_ipData  <= w_merged;
      r_ipCount <= w_count;
      r_ipLast  <= w_last;
    end else if (ip_drdy) begin
      r_ipSrdy  <= 1'b0;
    end
  end

  assign ip_srdy  = r_ipSrdy;
  assign ip_data  = r_ipData;
  assign ip_count = r_ipCount;
  assign ip_last  = r_ipLast;

endmodule

// File: tb/tb_sd_width_pack.sv
// tb_sd_width_pack: directed tables, reset and randomized checks for sd_width_pack.
// Expectations follow SD_WIDTH_PACK_LAST_EN the same way the design does.
module tb_sd_width_pack;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int CW = $clog2(R+1);

`ifdef SD_WIDTH_PACK_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          c_srdy;
  logic          c_drdy;
  logic [W-1:0]  c_data;
  logic          c_last;
  logic          ip_srdy;
  logic          ip_drdy;
  logic [W*R-1:0] ip_data;
  logic [CW-1:0] ip_count;
  logic          ip_last;

  sd_width_pack #(.width(W), .ratio(R)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data), .c_last(c_last),
    .ip_srdy(ip_srdy), .ip_drdy(ip_drdy), .ip_data(ip_data),
    .ip_count(ip_count), .ip_last(ip_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dutDrained = 0;
  int modelMade = 0;

  // Reference model: beats collected so far and the word the output should be holding.
  logic [W-1:0]   mBeats[$];
  logic           mHoldValid;
  logic [W*R-1:0] mData;
  logic [CW-1:0]  mCount;
  logic           mLast;

  typedef struct {
    logic          srdy;
    logic [W-1:0]  data;
    logic          last;
    logic          drdy;
    logic          expCDrdy;
    logic          expSrdy;
    logic [W*R-1:0] expData;
    logic [CW-1:0] expCount;
    logic          expLast;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(logic s, logic [W-1:0] d, logic l, logic dr,
                                 logic eDr, logic eS, logic [W*R-1:0] eD,
                                 logic [CW-1:0] eC, logic eL);
    vec_t v;
    v.srdy = s; v.data = d; v.last = l; v.drdy = dr;
    v.expCDrdy = eDr; v.expSrdy = eS; v.expData = eD; v.expCount = eC; v.expLast = eL;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mBeats.delete();
    mHoldValid = 1'b0;
    mData      = '0;
    mCount     = '0;
    mLast      = 1'b0;
  endtask

  task automatic checkOutput();
    bit completing;
    completing = (mBeats.size() == R-1) || (LastEn && c_last);
    check("c_drdy",   64'(c_drdy),   64'(!completing || !mHoldValid || ip_drdy));
    check("ip_srdy",  64'(ip_srdy),  64'(mHoldValid));
    check("ip_data",  64'(ip_data),  64'(mData));
    check("ip_count", 64'(ip_count), 64'(mCount));
    check("ip_last",  64'(ip_last),  64'(mLast));
  endtask

  task automatic applyStimulus(input logic s, input logic [W-1:0] d, input logic l, input logic dr);
    @(negedge clk);
    c_srdy  = s;
    c_data  = d;
    c_last  = l;
    ip_drdy = dr;
    #1;
    checkOutput();
  endtask

  // Commits one clock edge to the model using the handshake seen before the edge.
  task automatic advance();
    bit acc, drn, done;
    logic [W-1:0] d;
    logic l;
    acc  = c_srdy && c_drdy;
    drn  = ip_srdy && ip_drdy;
    d    = c_data;
    l    = c_last;
    done = 1'b0;
    @(posedge clk);
    if (drn) dutDrained++;
    if (acc) begin
      mBeats.push_back(d);
      if (mBeats.size() == R || (LastEn && l)) begin
        mData = '0;
        foreach (mBeats[i]) mData = mData + ((W*R)'(mBeats[i]) << (W*i));
        mCount     = CW'(mBeats.size());
        mLast      = LastEn && l;
        mHoldValid = 1'b1;
        mBeats.delete();
        modelMade++;
        done = 1'b1;
      end
    end
    if (!done && drn) mHoldValid = 1'b0;
  endtask

  task automatic runTable(input string tag);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].srdy, tbl[i].data, tbl[i].last, tbl[i].drdy);
      check($sformatf("%s[%0d].c_drdy", tag, i),   64'(c_drdy),   64'(tbl[i].expCDrdy));
      check($sformatf("%s[%0d].ip_srdy", tag, i),  64'(ip_srdy),  64'(tbl[i].expSrdy));
      check($sformatf("%s[%0d].ip_data", tag, i),  64'(ip_data),  64'(tbl[i].expData));
      check($sformatf("%s[%0d].ip_count", tag, i), 64'(ip_count), 64'(tbl[i].expCount));
      check($sformatf("%s[%0d].ip_last", tag, i),  64'(ip_last),  64'(tbl[i].expLast));
      advance();
    end
    tbl.delete();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".ip_srdy"},  64'(ip_srdy),  64'd0);
    check({tag, ".ip_data"},  64'(ip_data),  64'd0);
    check({tag, ".ip_count"}, 64'(ip_count), 64'd0);
    check({tag, ".ip_last"},  64'(ip_last),  64'd0);
  endtask

  initial begin
    int beats;
    int cyc;
    int drainedBase;
    int madeBase;

    reset_n = 1'b0;
    c_srdy  = 1'b0;
    c_data  = '0;
    c_last  = 1'b0;
    ip_drdy = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Full words, back-to-back words, then backpressure on the completing beat.
    tbl.push_back(mkVec(1, 8'h11, 0, 1, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mkVec(1, 8'h22, 0, 1, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mkVec(1, 8'h33, 0, 1, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mkVec(1, 8'h44, 0, 1, 1, 0, 32'h0,        0, 0));
    tbl.push_back(mkVec(1, 8'h55, 0, 1, 1, 1, 32'h44332211, 4, 0));
    tbl.push_back(mkVec(1, 8'h66, 0, 1, 1, 0, 32'h44332211, 4, 0));
    tbl.push_back(mkVec(1, 8'h77, 0, 1, 1, 0, 32'h44332211, 4, 0));
    tbl.push_back(mkVec(1, 8'h88, 0, 1, 1, 0, 32'h44332211, 4, 0));
    tbl.push_back(mkVec(1, 8'h99, 0, 1, 1, 1, 32'h88776655, 4, 0));
    tbl.push_back(mkVec(1, 8'hAA, 0, 1, 1, 0, 32'h88776655, 4, 0));
    tbl.push_back(mkVec(1, 8'hBB, 0, 1, 1, 0, 32'h88776655, 4, 0));
    tbl.push_back(mkVec(1, 8'hCC, 0, 1, 1, 0, 32'h88776655, 4, 0));
    tbl.push_back(mkVec(1, 8'h01, 0, 0, 1, 1, 32'hCCBBAA99, 4, 0));
    tbl.push_back(mkVec(1, 8'h02, 0, 0, 1, 1, 32'hCCBBAA99, 4, 0));
    tbl.push_back(mkVec(1, 8'h03, 0, 0, 1, 1, 32'hCCBBAA99, 4, 0));
    tbl.push_back(mkVec(1, 8'h04, 0, 0, 0, 1, 32'hCCBBAA99, 4, 0));
    tbl.push_back(mkVec(1, 8'h04, 0, 0, 0, 1, 32'hCCBBAA99, 4, 0));
    tbl.push_back(mkVec(1, 8'h04, 0, 1, 1, 1, 32'hCCBBAA99, 4, 0));
    tbl.push_back(mkVec(0, 8'h00, 0, 0, 1, 1, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(0, 8'h00, 0, 1, 1, 1, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(0, 8'h00, 0, 1, 1, 0, 32'h04030201, 4, 0));
    runTable("full");

`ifdef SD_WIDTH_PACK_LAST_EN
    tbl.push_back(mkVec(1, 8'hAA, 0, 1, 1, 0, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(1, 8'hBB, 1, 1, 1, 0, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(1, 8'hCC, 1, 1, 1, 1, 32'h0000BBAA, 2, 1));
    tbl.push_back(mkVec(0, 8'h00, 0, 1, 1, 1, 32'h000000CC, 1, 1));
    tbl.push_back(mkVec(0, 8'h00, 0, 1, 1, 0, 32'h000000CC, 1, 1));
    tbl.push_back(mkVec(0, 8'h00, 0, 1, 1, 0, 32'h000000CC, 1, 1));
    runTable("flush");
`else
    tbl.push_back(mkVec(1, 8'hAA, 0, 1, 1, 0, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(1, 8'hBB, 1, 1, 1, 0, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(1, 8'hCC, 1, 1, 1, 0, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(0, 8'h00, 0, 1, 1, 0, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(1, 8'hDD, 0, 1, 1, 0, 32'h04030201, 4, 0));
    tbl.push_back(mkVec(0, 8'h00, 0, 1, 1, 1, 32'hDDCCBBAA, 4, 0));
    runTable("nolast");
`endif

    // Reset mid-word with a held word pending.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, W'(8'h10 * (i + 1)), 1'b0, 1'b0);
      advance();
    end
    check("preReset.ip_srdy", 64'(ip_srdy), 64'd1);
    @(negedge clk);
    c_srdy  = 1'b0;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkAllZero("midReset");
    checkOutput();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < R; i++) begin
      applyStimulus(1'b1, W'(i + 1), 1'b0, 1'b1);
      advance();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    check("postReset.ip_srdy",  64'(ip_srdy),  64'd1);
    check("postReset.ip_data",  64'(ip_data),  64'h04030201);
    check("postReset.ip_count", 64'(ip_count), 64'd4);
    advance();

    // Randomized traffic against the model.
    drainedBase = dutDrained;
    madeBase    = modelMade;
    beats = 0;
    cyc   = 0;
    while (beats < 1000 && cyc < 20000) begin
      applyStimulus($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 9) < 6);
      if (c_srdy && c_drdy) beats++;
      advance();
      cyc++;
    end
    check("random.beatsAccepted", 64'(beats), 64'd1000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      advance();
    end
    check("random.wordsDrained", 64'(dutDrained - drainedBase), 64'(modelMade - madeBase));
    check("random.idleSrdy", 64'(ip_srdy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
